// File: rtl/rnd_led_pattern_gen.sv
// rtl/rnd_led_pattern_gen.sv - LFSR-driven random pattern source for the four-RGB-LED display
module rnd_led_pattern_gen #(
  parameter int          TICK_DIV = 50_000_000,
  parameter logic [12:0] SEED     = 13'h1ACE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        step,
  input  logic        seed_load,
  input  logic [12:0] seed,
  output logic [12:0] rnd,
  output logic [11:0] pattern,
  output logic        update
);

  localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic {STOP, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             step_q;
  logic             feedback;
  logic             step_rise;
  logic [11:0]      sampled;

  // Taps for x^13+x^12+x^11+x^8+1 in shift-left Fibonacci form
  assign feedback  = rnd[12] ^ rnd[11] ^ rnd[10] ^ rnd[7];
  assign step_rise = step & ~step_q;
  // A latched pattern must never light nothing, so all-zero maps to all-on
  assign sampled   = (rnd[11:0] == 12'h000) ? 12'hFFF : rnd[11:0];

  // Free-running LFSR with seed load and lock-up recovery
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rnd <= SEED;
    end else if (seed_load) begin
      rnd <= (seed == 13'd0) ? SEED : seed;
    end else if (rnd == 13'd0) begin
      rnd <= SEED;
    end else begin
      rnd <= {rnd[11:0], feedback};
    end
  end

  // Run/stop FSM with prescaler; latches the pattern on a tick (RUN) or a step edge (STOP)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= STOP;
      cnt     <= '0;
      step_q  <= 1'b0;
      pattern <= 12'h000;
      update  <= 1'b0;
    end else begin
      step_q <= step;
      update <= 1'b0;
      case (state)
        STOP: begin
          if (step_rise) begin
            pattern <= sampled;
            update  <= 1'b1;
          end
          if (en) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (cnt == CNT_LAST) begin
            pattern <= sampled;
            update  <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          // Leaving RUN drops any partial count so the next run starts fresh
          if (!en) begin
            state <= STOP;
            cnt   <= '0;
          end
        end
        default: begin
          state <= STOP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rnd_led_pattern_gen.sv
// tb/tb_rnd_led_pattern_gen.sv - directed table-driven bench for rnd_led_pattern_gen
module tb_rnd_led_pattern_gen;

  localparam int          TD = 4;
  localparam logic [12:0] SD = 13'h0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        step = 1'b0;
  logic        seed_load = 1'b0;
  logic [12:0] seed = 13'd0;
  logic [12:0] rnd;
  logic [11:0] pattern;
  logic        update;

  int checks = 0;
  int errors = 0;

  logic [12:0] exp_rnd;
  logic [11:0] exp_pat;

  typedef struct {
    logic        en;
    logic [12:0] rnd;
    logic [11:0] pat;
    logic        upd;
  } vec_t;

  vec_t tbl [17];

  rnd_led_pattern_gen #(
    .TICK_DIV(TD),
    .SEED    (SD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .step     (step),
    .seed_load(seed_load),
    .seed     (seed),
    .rnd      (rnd),
    .pattern  (pattern),
    .update   (update)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] lfsr_model(input logic [12:0] cur, input logic ld,
                                             input logic [12:0] nv);
    if (ld) return (nv == 13'd0) ? SD : nv;
    if (cur == 13'd0) return SD;
    return {cur[11:0], ^(cur & 13'h1C80)};
  endfunction

  function automatic logic [11:0] guard(input logic [12:0] r);
    return (r[11:0] == 12'h000) ? 12'hFFF : r[11:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge; expected rnd follows the model, pattern follows guard(pre-edge rnd) on an update
  task automatic cyc(input string tag, input logic exp_upd);
    logic [12:0] pre;
    pre = exp_rnd;
    @(posedge clk);
    #1;
    exp_rnd = lfsr_model(pre, seed_load, seed);
    if (exp_upd) exp_pat = guard(pre);
    check({tag, " rnd"}, 32'(rnd), 32'(exp_rnd));
    check({tag, " update"}, 32'(update), 32'(exp_upd));
    check({tag, " pattern"}, 32'(pattern), 32'(exp_pat));
  endtask

  initial begin
    // en, rnd, pattern, update after edges E0..E16 (E0 = first edge out of reset)
    tbl[0]  = '{1'b1, 13'h0002, 12'h000, 1'b0};
    tbl[1]  = '{1'b1, 13'h0004, 12'h000, 1'b0};
    tbl[2]  = '{1'b1, 13'h0008, 12'h000, 1'b0};
    tbl[3]  = '{1'b1, 13'h0010, 12'h000, 1'b0};
    tbl[4]  = '{1'b1, 13'h0020, 12'h010, 1'b1};
    tbl[5]  = '{1'b1, 13'h0040, 12'h010, 1'b0};
    tbl[6]  = '{1'b1, 13'h0080, 12'h010, 1'b0};
    tbl[7]  = '{1'b1, 13'h0101, 12'h010, 1'b0};
    tbl[8]  = '{1'b1, 13'h0202, 12'h101, 1'b1};
    tbl[9]  = '{1'b1, 13'h0404, 12'h101, 1'b0};
    tbl[10] = '{1'b1, 13'h0809, 12'h101, 1'b0};
    tbl[11] = '{1'b1, 13'h1013, 12'h101, 1'b0};
    tbl[12] = '{1'b0, 13'h0027, 12'h013, 1'b1};
    tbl[13] = '{1'b0, 13'h004E, 12'h013, 1'b0};
    tbl[14] = '{1'b0, 13'h009C, 12'h013, 1'b0};
    tbl[15] = '{1'b0, 13'h0139, 12'h013, 1'b0};
    tbl[16] = '{1'b0, 13'h0272, 12'h013, 1'b0};

    // Reset held across edges
    repeat (2) @(posedge clk);
    #1;
    check("reset rnd", 32'(rnd), 32'(SD));
    check("reset pattern", 32'(pattern), 32'h0);
    check("reset update", 32'(update), 32'h0);

    // Release with en=1; LFSR sequence, run cadence, en dropped on tick edge
    rst = 1'b1;
    for (int i = 0; i < 17; i++) begin
      en = tbl[i].en;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d rnd", i), 32'(rnd), 32'(tbl[i].rnd));
      check($sformatf("vec%0d pattern", i), 32'(pattern), 32'(tbl[i].pat));
      check($sformatf("vec%0d update", i), 32'(update), 32'(tbl[i].upd));
    end
    exp_rnd = tbl[16].rnd;
    exp_pat = tbl[16].pat;

    // Manual step held high: one pulse, then a second step after a low cycle
    step = 1'b1;
    cyc("step rise", 1'b1);
    for (int i = 0; i < 4; i++) cyc("step held", 1'b0);
    step = 1'b0;
    cyc("step low", 1'b0);
    step = 1'b1;
    cyc("step again", 1'b1);
    step = 1'b0;
    cyc("step release", 1'b0);

    // Seed load, then step into a zero low field
    seed_load = 1'b1;
    seed = 13'h1000;
    cyc("seed load", 1'b0);
    check("seed load value", 32'(rnd), 32'h1000);
    seed_load = 1'b0;
    step = 1'b1;
    cyc("zero guard step", 1'b1);
    check("zero guard pattern", 32'(pattern), 32'hFFF);
    step = 1'b0;
    seed_load = 1'b1;
    seed = 13'd0;
    cyc("seed zero", 1'b0);
    check("seed zero fallback", 32'(rnd), 32'(SD));
    seed_load = 1'b0;

    // Seed load colliding with a tick
    en = 1'b1;
    cyc("enter run", 1'b0);
    for (int i = 0; i < 3; i++) cyc("run count", 1'b0);
    seed_load = 1'b1;
    seed = 13'h0ABC;
    cyc("tick with load", 1'b1);
    check("tick load rnd", 32'(rnd), 32'h0ABC);
    seed_load = 1'b0;
    cyc("run cnt1", 1'b0);
    cyc("run cnt2", 1'b0);

    // Asynchronous reset between edges at cnt=2
    #3;
    rst = 1'b0;
    #1;
    check("async reset rnd", 32'(rnd), 32'(SD));
    check("async reset pattern", 32'(pattern), 32'h0);
    check("async reset update", 32'(update), 32'h0);
    exp_rnd = SD;
    exp_pat = 12'h000;
    @(posedge clk);
    #1;
    check("reset hold pattern", 32'(pattern), 32'h0);
    check("reset hold rnd", 32'(rnd), 32'(SD));
    rst = 1'b1;
    for (int i = 0; i < TD; i++) cyc("post reset quiet", 1'b0);
    cyc("post reset tick", 1'b1);
    check("post reset pattern", 32'(pattern), 32'h010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
